// File: rtl/spi_slave_shifter_if.sv
// Bus bundle between the SPI slave shift engine and its pads / SPDR register side.
// With SPI_SLV_OVERRUN_EN defined, the bundle also carries the OVR overrun flag.
interface spi_slave_shifter_if #(
  parameter int DWIDTH = 8
);
  logic              SS_n;
  logic              SCK;
  logic              MOSI;
  logic              CPOL;
  logic              CPHA;
  logic              SPDR_wr_en;
  logic [DWIDTH-1:0] SPDR_in;
  logic              SPDR_rd_en;
  logic [DWIDTH-1:0] SPDR_out;
  logic              MISO;
  logic              MISO_oe;
  logic              SPIF;
  logic              WCOL;
  logic              busy;
`ifdef SPI_SLV_OVERRUN_EN
  logic              OVR;
`endif

  modport slave (
    input  SS_n, SCK, MOSI, CPOL, CPHA, SPDR_wr_en, SPDR_in, SPDR_rd_en,
    output SPDR_out, MISO, MISO_oe, SPIF, WCOL, busy
`ifdef SPI_SLV_OVERRUN_EN
    , output OVR
`endif
  );

  modport master (
    output SS_n, SCK, MOSI, CPOL, CPHA, SPDR_wr_en, SPDR_in, SPDR_rd_en,
    input  SPDR_out, MISO, MISO_oe, SPIF, WCOL, busy
`ifdef SPI_SLV_OVERRUN_EN
    , input OVR
`endif
  );
endinterface

// File: rtl/spi_slave_shifter.sv
// Slave-side SPI shift engine: oversamples SCK/SS_n/MOSI on Shift_clk, shifts frames, drives MISO.
// Optional SPI_SLV_OVERRUN_EN adds the OVR flag and keeps the first unread byte on overrun.
//
// state  | meaning
// IDLE   | SS_n high; MISO tristated, SPDR writes go straight to the shift register
// ACTIVE | SS_n low; sample/drive edges shift the frame, SPIF raised per completed byte
module spi_slave_shifter #(
  parameter int DWIDTH = 8
) (
  input  logic               Shift_clk,
  input  logic               rst,
  spi_slave_shifter_if.slave bus
);

  localparam int CW = $clog2(DWIDTH + 1);

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  state_t state_q, state_d;

  logic [1:0]        ss_sync;
  logic [2:0]        sck_sync;
  logic [1:0]        mosi_sync;

  logic [DWIDTH-1:0] shreg_q;
  logic [DWIDTH-1:0] tx_hold_q;
  logic [DWIDTH-1:0] spdr_out_q;
  logic [CW-1:0]     count_q;
  logic              fresh_q;
  logic              miso_q;
  logic              spif_q;
  logic              wcol_q;
`ifdef SPI_SLV_OVERRUN_EN
  logic              ovr_q;
`endif

  logic              ss_s;
  logic              mosi_s;
  logic              lead_edge;
  logic              trail_edge;
  logic              sample_edge;
  logic              drive_edge;
  logic              any_edge;
  logic [DWIDTH-1:0] shreg_shift;

  logic              enter;
  logic              leave;
  logic              do_sample;
  logic              do_drive;
  logic              done;
  logic              wr_ok;
  logic              wr_col;

  // SCK is synchronised as SCK^CPOL so the idle level is always 0 and the
  // synchroniser can reset to a constant regardless of the selected mode.
  always_ff @(posedge Shift_clk or negedge rst) begin
    if (!rst) begin
      ss_sync   <= 2'b11;
      sck_sync  <= '0;
      mosi_sync <= '0;
    end else begin
      ss_sync   <= {ss_sync[0], bus.SS_n};
      sck_sync  <= {sck_sync[1:0], bus.SCK ^ bus.CPOL};
      mosi_sync <= {mosi_sync[0], bus.MOSI};
    end
  end

  assign ss_s        = ss_sync[1];
  assign mosi_s      = mosi_sync[1];
  assign lead_edge   = sck_sync[1] & ~sck_sync[2];
  assign trail_edge  = ~sck_sync[1] & sck_sync[2];
  assign sample_edge = bus.CPHA ? trail_edge : lead_edge;
  assign drive_edge  = bus.CPHA ? lead_edge : trail_edge;
  assign any_edge    = lead_edge | trail_edge;
  assign shreg_shift = {shreg_q[DWIDTH-2:0], mosi_s};

  always_ff @(posedge Shift_clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    enter     = 1'b0;
    leave     = 1'b0;
    do_sample = 1'b0;
    do_drive  = 1'b0;
    done      = 1'b0;
    wr_ok     = 1'b0;
    wr_col    = 1'b0;
    case (state_q)
      IDLE: begin
        wr_ok = bus.SPDR_wr_en;
        if (!ss_s) begin
          state_d = ACTIVE;
          enter   = 1'b1;
        end
      end
      ACTIVE: begin
        if (ss_s) begin
          state_d = IDLE;
          leave   = 1'b1;
        end else begin
          do_sample = sample_edge;
          do_drive  = drive_edge;
          done      = sample_edge && (count_q == CW'(DWIDTH - 1));
        end
        // A write is only safe before the first edge of a frame; anything later collides.
        if (bus.SPDR_wr_en) begin
          if (fresh_q && !any_edge && !ss_s) wr_ok  = 1'b1;
          else                               wr_col = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Shift_clk or negedge rst) begin
    if (!rst) begin
      shreg_q    <= '0;
      tx_hold_q  <= '0;
      spdr_out_q <= '0;
      count_q    <= '0;
      fresh_q    <= 1'b0;
      miso_q     <= 1'b0;
      spif_q     <= 1'b0;
      wcol_q     <= 1'b0;
`ifdef SPI_SLV_OVERRUN_EN
      ovr_q      <= 1'b0;
`endif
    end else begin
      if (wr_ok) begin
        shreg_q   <= bus.SPDR_in;
        tx_hold_q <= bus.SPDR_in;
        if (state_q == ACTIVE) miso_q <= bus.SPDR_in[DWIDTH-1];
      end

      if (enter) begin
        count_q <= '0;
        fresh_q <= 1'b1;
        miso_q  <= wr_ok ? bus.SPDR_in[DWIDTH-1] : shreg_q[DWIDTH-1];
      end

      // Partial frames are dropped and the last written byte is re-armed.
      if (leave) begin
        count_q <= '0;
        fresh_q <= 1'b0;
        miso_q  <= 1'b0;
        shreg_q <= tx_hold_q;
      end

      if (do_sample) begin
        shreg_q <= shreg_shift;
        count_q <= done ? '0 : count_q + CW'(1);
      end

      if (do_drive) miso_q <= shreg_q[DWIDTH-1];

      if (do_sample || do_drive) fresh_q <= 1'b0;
      if (done)                  fresh_q <= 1'b1;

      if (bus.SPDR_rd_en) begin
        spif_q <= 1'b0;
        wcol_q <= 1'b0;
`ifdef SPI_SLV_OVERRUN_EN
        ovr_q  <= 1'b0;
`endif
      end

      if (wr_col) wcol_q <= 1'b1;

      if (done) begin
        spif_q <= 1'b1;
`ifdef SPI_SLV_OVERRUN_EN
        if (spif_q && !bus.SPDR_rd_en) ovr_q      <= 1'b1;
        else                           spdr_out_q <= shreg_shift;
`else
        spdr_out_q <= shreg_shift;
`endif
      end
    end
  end

  assign bus.SPDR_out = spdr_out_q;
  assign bus.MISO     = miso_q;
  assign bus.MISO_oe  = (state_q == ACTIVE);
  assign bus.busy     = (state_q == ACTIVE);
  assign bus.SPIF     = spif_q;
  assign bus.WCOL     = wcol_q;
`ifdef SPI_SLV_OVERRUN_EN
  assign bus.OVR      = ovr_q;
`endif

endmodule
